bach_rsp_router: RTL and testbench

- Sits between the 3-agent arbiter and the memory controller (DI) port, on the return path.
- Records the owner and burst length of every read command the controller accepts, in an in-order tracking FIFO.
- Steers each returning read beat (di_AvlReadDataValid) to the agent that issued that read.
- Back-pressures the arbiter when the FIFO is full, and flags protocol errors.

---
 rtl/bach_rsp_router.sv | 118 +++++++++++
 tb/tb_bach_rsp_router.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bach_rsp_router.sv
// Read-response router: tracks accepted DI reads in order and steers
// returning beats back to the agent that issued each read.
module bach_rsp_router #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int BC_W   = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [2:0]        cmd_Grant,
  input  logic              cmd_AvlRead,
  input  logic [BC_W-1:0]   cmd_AvlBurstCount,
  input  logic              di_AvlWaitRequest,
  input  logic [DATA_W-1:0] di_AvlReadData,
  input  logic              di_AvlReadDataValid,
  output logic [DATA_W-1:0] d0_AvlReadData,
  output logic [DATA_W-1:0] d1_AvlReadData,
  output logic [DATA_W-1:0] d2_AvlReadData,
  output logic              d0_AvlReadDataValid,
  output logic              d1_AvlReadDataValid,
  output logic              d2_AvlReadDataValid,
  output logic              rsp_Full,
  output logic [$clog2(DEPTH):0] rsp_Outstanding,
  output logic              rsp_Error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);

  logic [1:0]      ownQ [DEPTH];
  logic [BC_W-1:0] bcQ  [DEPTH];

  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic [CW-1:0]   count;
  logic [BC_W-1:0] beatCnt;
  logic [DATA_W-1:0] rdData;
  logic [2:0]      rdValid;

  logic            accept;
  logic            oneHot;
  logic            full;
  logic            empty;
  logic            push;
  logic            beat;
  logic            pop;
  logic            bcZero;
  logic            errSet;
  logic [1:0]      owner;
  logic [1:0]      headOwn;
  logic [BC_W-1:0] headBc;
  logic [BC_W-1:0] pushBc;

  assign accept  = cmd_AvlRead & ~di_AvlWaitRequest;
  assign oneHot  = (cmd_Grant == 3'b001) | (cmd_Grant == 3'b010) |
                   (cmd_Grant == 3'b100);
  // Valid only for one-hot grants: 001->0, 010->1, 100->2
  assign owner   = {cmd_Grant[2], cmd_Grant[1]};
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign bcZero  = (cmd_AvlBurstCount == '0);
  assign pushBc  = bcZero ? BC_ONE : cmd_AvlBurstCount;
  assign push    = accept & oneHot & ~full;
  assign beat    = di_AvlReadDataValid & ~empty;
  assign headOwn = ownQ[rdPtr];
  assign headBc  = bcQ[rdPtr];
  assign pop     = beat & (beatCnt == headBc - BC_ONE);
  assign errSet  = (accept & (~oneHot | full | bcZero)) |
                   (di_AvlReadDataValid & empty);

  always_ff @(posedge Clk) begin
    if (push) begin
      ownQ[wrPtr] <= owner;
      bcQ[wrPtr]  <= pushBc;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      beatCnt   <= '0;
      rdData    <= '0;
      rdValid   <= '0;
      rsp_Error <= 1'b0;
    end else begin
      if (push)
        wrPtr <= wrPtr + PW'(1);
      if (pop)
        rdPtr <= rdPtr + PW'(1);
      if (push & ~pop)
        count <= count + CW'(1);
      else if (pop & ~push)
        count <= count - CW'(1);
      if (pop)
        beatCnt <= '0;
      else if (beat)
        beatCnt <= beatCnt + BC_ONE;
      if (beat)
        rdData <= di_AvlReadData;
      rdValid <= beat ? (3'b001 << headOwn) : 3'b000;
      if (errSet)
        rsp_Error <= 1'b1;
    end
  end

  assign d0_AvlReadData      = rdData;
  assign d1_AvlReadData      = rdData;
  assign d2_AvlReadData      = rdData;
  assign d0_AvlReadDataValid = rdValid[0];
  assign d1_AvlReadDataValid = rdValid[1];
  assign d2_AvlReadDataValid = rdValid[2];
  assign rsp_Full            = full;
  assign rsp_Outstanding     = count;

endmodule

// File: tb/tb_bach_rsp_router.sv
// Directed bench for bach_rsp_router: routing, full/overflow,
// push+pop, orphans, bc=0 and async reset mid-burst.
module tb_bach_rsp_router;

  localparam int DATA_W = 32;
  localparam int BC_W   = 3;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [2:0]        cmd_Grant;
  logic              cmd_AvlRead;
  logic [BC_W-1:0]   cmd_AvlBurstCount;
  logic              di_AvlWaitRequest;
  logic [DATA_W-1:0] di_AvlReadData;
  logic              di_AvlReadDataValid;
  logic [DATA_W-1:0] d0Data, d1Data, d2Data;
  logic              d0Valid, d1Valid, d2Valid;
  logic              rspFull;
  logic [2:0]        rspOut;
  logic              rspErr;

  int total = 0;
  int passed = 0;

  bach_rsp_router #(.DEPTH(4), .DATA_W(DATA_W), .BC_W(BC_W)) dut (
    .Clk                 (Clk),
    .Rst                 (Rst),
    .cmd_Grant           (cmd_Grant),
    .cmd_AvlRead         (cmd_AvlRead),
    .cmd_AvlBurstCount   (cmd_AvlBurstCount),
    .di_AvlWaitRequest   (di_AvlWaitRequest),
    .di_AvlReadData      (di_AvlReadData),
    .di_AvlReadDataValid (di_AvlReadDataValid),
    .d0_AvlReadData      (d0Data),
    .d1_AvlReadData      (d1Data),
    .d2_AvlReadData      (d2Data),
    .d0_AvlReadDataValid (d0Valid),
    .d1_AvlReadDataValid (d1Valid),
    .d2_AvlReadDataValid (d2Valid),
    .rsp_Full            (rspFull),
    .rsp_Outstanding     (rspOut),
    .rsp_Error           (rspErr)
  );

  always #5 Clk = ~Clk;

  function automatic logic [2:0] vld();
    return {d2Valid, d1Valid, d0Valid};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    cmd_Grant           = 3'b000;
    cmd_AvlRead         = 1'b0;
    cmd_AvlBurstCount   = '0;
    di_AvlWaitRequest   = 1'b0;
    di_AvlReadData      = '0;
    di_AvlReadDataValid = 1'b0;
  endtask

  task automatic doReset();
    idle();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic pushCmd(input logic [2:0] g, input logic [BC_W-1:0] bc);
    cmd_Grant         = g;
    cmd_AvlRead       = 1'b1;
    cmd_AvlBurstCount = bc;
    tick();
    idle();
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if (vld() !== 3'b000 || d0Data !== '0 || d1Data !== '0 || d2Data !== '0)
      $display("FAIL reset_outputs valid=%b d0=%h d1=%h d2=%h want 000/0",
               vld(), d0Data, d1Data, d2Data);
    else passed++;
    total++;
    if (rspFull !== 1'b0 || rspOut !== 3'd0 || rspErr !== 1'b0)
      $display("FAIL reset_status full=%b out=%0d err=%b want 0/0/0",
               rspFull, rspOut, rspErr);
    else passed++;
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] dv [4];
    dv[0] = 32'hA000_0000; dv[1] = 32'hA111_1111;
    dv[2] = 32'hA222_2222; dv[3] = 32'hA333_3333;
    doReset();
    pushCmd(3'b001, 3'd4);
    total++;
    if (rspOut !== 3'd1)
      $display("FAIL single_occ got=%0d want=1", rspOut);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      di_AvlReadDataValid = 1'b1;
      di_AvlReadData      = dv[i];
      tick();
      total++;
      if (vld() !== 3'b001 || d0Data !== dv[i])
        $display("FAIL single_beat%0d valid=%b data=%h want 001/%h",
                 i, vld(), d0Data, dv[i]);
      else passed++;
      total++;
      if (rspOut !== ((i == 3) ? 3'd0 : 3'd1))
        $display("FAIL single_occ%0d got=%0d want=%0d",
                 i, rspOut, (i == 3) ? 0 : 1);
      else passed++;
    end
    idle();
    tick();
    total++;
    if (vld() !== 3'b000 || d0Data !== dv[3] || rspErr !== 1'b0)
      $display("FAIL single_after valid=%b data=%h err=%b want 000/%h/0",
               vld(), d0Data, rspErr, dv[3]);
    else passed++;
  endtask

  task automatic test_interleave();
    logic [2:0] exp [6];
    exp[0] = 3'b010; exp[1] = 3'b010; exp[2] = 3'b100;
    exp[3] = 3'b100; exp[4] = 3'b100; exp[5] = 3'b001;
    doReset();
    pushCmd(3'b010, 3'd2);
    pushCmd(3'b100, 3'd3);
    pushCmd(3'b001, 3'd1);
    total++;
    if (rspOut !== 3'd3)
      $display("FAIL inter_occ got=%0d want=3", rspOut);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      di_AvlReadDataValid = 1'b1;
      di_AvlReadData      = 32'hB000_0000 + i;
      tick();
      total++;
      if (vld() !== exp[i] || d1Data !== 32'hB000_0000 + i)
        $display("FAIL inter_beat%0d valid=%b data=%h want %b/%h",
                 i, vld(), d1Data, exp[i], 32'hB000_0000 + i);
      else passed++;
    end
    idle();
    total++;
    if (rspOut !== 3'd0 || rspErr !== 1'b0)
      $display("FAIL inter_end out=%0d err=%b want 0/0", rspOut, rspErr);
    else passed++;
  endtask

  task automatic test_full();
    doReset();
    for (int i = 0; i < 4; i++) pushCmd(3'b001, 3'd1);
    total++;
    if (rspFull !== 1'b1 || rspOut !== 3'd4 || rspErr !== 1'b0)
      $display("FAIL full_set full=%b out=%0d err=%b want 1/4/0",
               rspFull, rspOut, rspErr);
    else passed++;
    pushCmd(3'b010, 3'd1);
    total++;
    if (rspErr !== 1'b1 || rspOut !== 3'd4)
      $display("FAIL full_overflow err=%b out=%0d want 1/4", rspErr, rspOut);
    else passed++;
    di_AvlReadDataValid = 1'b1;
    tick();
    total++;
    if (rspFull !== 1'b0 || rspOut !== 3'd3 || vld() !== 3'b001)
      $display("FAIL full_drop full=%b out=%0d valid=%b want 0/3/001",
               rspFull, rspOut, vld());
    else passed++;
    tick(); tick(); tick();
    idle();
    total++;
    if (rspOut !== 3'd0 || vld() !== 3'b001)
      $display("FAIL full_drain out=%0d valid=%b want 0/001", rspOut, vld());
    else passed++;
  endtask

  task automatic test_push_pop();
    doReset();
    pushCmd(3'b010, 3'd2);
    pushCmd(3'b100, 3'd1);
    di_AvlReadDataValid = 1'b1;
    tick();
    total++;
    if (rspOut !== 3'd2 || vld() !== 3'b010)
      $display("FAIL pp_first out=%0d valid=%b want 2/010", rspOut, vld());
    else passed++;
    cmd_Grant         = 3'b001;
    cmd_AvlRead       = 1'b1;
    cmd_AvlBurstCount = 3'd1;
    tick();
    cmd_AvlRead = 1'b0;
    cmd_Grant   = 3'b000;
    total++;
    if (rspOut !== 3'd2 || vld() !== 3'b010)
      $display("FAIL pp_same out=%0d valid=%b want 2/010", rspOut, vld());
    else passed++;
    tick();
    total++;
    if (rspOut !== 3'd1 || vld() !== 3'b100)
      $display("FAIL pp_next out=%0d valid=%b want 1/100", rspOut, vld());
    else passed++;
    tick();
    idle();
    total++;
    if (rspOut !== 3'd0 || vld() !== 3'b001 || rspErr !== 1'b0)
      $display("FAIL pp_last out=%0d valid=%b err=%b want 0/001/0",
               rspOut, vld(), rspErr);
    else passed++;
  endtask

  task automatic test_orphan_bc0();
    doReset();
    di_AvlReadDataValid = 1'b1;
    di_AvlReadData      = 32'hDEAD_BEEF;
    tick();
    idle();
    total++;
    if (vld() !== 3'b000 || rspErr !== 1'b1 || rspOut !== 3'd0)
      $display("FAIL orphan valid=%b err=%b out=%0d want 000/1/0",
               vld(), rspErr, rspOut);
    else passed++;
    doReset();
    pushCmd(3'b100, 3'd0);
    total++;
    if (rspErr !== 1'b1 || rspOut !== 3'd1)
      $display("FAIL bc0_push err=%b out=%0d want 1/1", rspErr, rspOut);
    else passed++;
    di_AvlReadDataValid = 1'b1;
    di_AvlReadData      = 32'hC0DE_0002;
    tick();
    idle();
    total++;
    if (vld() !== 3'b100 || d2Data !== 32'hC0DE_0002 || rspOut !== 3'd0)
      $display("FAIL bc0_beat valid=%b data=%h out=%0d want 100/c0de0002/0",
               vld(), d2Data, rspOut);
    else passed++;
    tick();
    total++;
    if (vld() !== 3'b000)
      $display("FAIL bc0_after valid=%b want 000", vld());
    else passed++;
  endtask

  task automatic test_async_reset();
    doReset();
    pushCmd(3'b001, 3'd4);
    di_AvlReadDataValid = 1'b1;
    di_AvlReadData      = 32'hE000_0001;
    tick();
    di_AvlReadData      = 32'hE000_0002;
    tick();
    total++;
    if (vld() !== 3'b001 || d0Data !== 32'hE000_0002)
      $display("FAIL ar_beat2 valid=%b data=%h want 001/e0000002",
               vld(), d0Data);
    else passed++;
    idle();
    #3 Rst = 1'b1;
    #1;
    total++;
    if (vld() !== 3'b000 || d0Data !== '0 || rspOut !== 3'd0 ||
        rspErr !== 1'b0)
      $display("FAIL ar_immediate valid=%b data=%h out=%0d err=%b want 0s",
               vld(), d0Data, rspOut, rspErr);
    else passed++;
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      di_AvlReadDataValid = 1'b1;
      di_AvlReadData      = 32'hE000_0003 + i;
      tick();
      total++;
      if (vld() !== 3'b000 || rspErr !== 1'b1)
        $display("FAIL ar_orphan%0d valid=%b err=%b want 000/1",
                 i, vld(), rspErr);
      else passed++;
    end
    idle();
  endtask

  initial begin
    Rst = 1'b1;
    idle();
    test_reset();
    test_single();
    test_interleave();
    test_full();
    test_push_pop();
    test_orphan_bc0();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
